// File: rtl/bounce_gen_pkg.sv
// Shared types and helpers for the bounce_gen switch emulator.
// The segment-length helper is also used by benches to predict bounce timing.
package bounce_gen_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BOUNCE_HI = 3'd1,
        BOUNCE_LO = 3'd2,
        SETTLE    = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    // Low delay_w LFSR bits give the segment length; zero would stall, so it becomes 1.
    function automatic int unsigned seg_len(input logic [LFSR_W-1:0] lfsr,
                                            input int unsigned       delay_w);
        int unsigned d;
        d = 32'(lfsr) & ((32'd1 << delay_w) - 32'd1);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr.sv
// Free-running Galois LFSR, shift right; reloaded only by reset so runs are reproducible.
module bounce_gen_lfsr
    import bounce_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] MASK  = LFSR_MASK,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [WIDTH-1:0] state_o
);

    // An all-zero state would lock the register, so a zero seed is replaced.
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= (state_q >> 1) ^ (state_q[0] ? MASK : '0);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical switch emulator: drives a raw switch line to a commanded level
// with a programmable number of pseudo-random bounce pulses before settling.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int unsigned       DELAY_W       = 4,
    parameter int unsigned       BOUNCE_W      = 4,
    parameter int unsigned       STABLE_CYCLES = 32,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    input  logic                cmd_level_i,
    input  logic [BOUNCE_W-1:0] cmd_bounces_i,
    output logic                cmd_ready_o,
    output logic                sw_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned         SETTLE_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(STABLE_CYCLES);

    state_e              state_q;
    logic                sw_q;
    logic                target_q;
    logic [BOUNCE_W-1:0] bounce_q;
    logic [DELAY_W-1:0]  seg_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [LFSR_W-1:0]   lfsr;
    logic [DELAY_W-1:0]  seg_d;

    bounce_gen_lfsr #(
        .WIDTH (LFSR_W),
        .MASK  (LFSR_MASK),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .state_o (lfsr)
    );

    // Length of the segment that starts at the coming edge.
    assign seg_d = DELAY_W'(seg_len(lfsr, DELAY_W));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sw_q     <= 1'b0;
            target_q <= 1'b0;
            bounce_q <= '0;
            seg_q    <= '0;
            settle_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cmd_valid_i) begin
                        // sw_q moves to the target at the accept edge; when the
                        // target already matches the line this is a no-op.
                        target_q <= cmd_level_i;
                        sw_q     <= cmd_level_i;
                        if (cmd_bounces_i != '0) begin
                            state_q  <= BOUNCE_HI;
                            bounce_q <= cmd_bounces_i;
                            seg_q    <= seg_d;
                        end else begin
                            state_q  <= SETTLE;
                            settle_q <= SETTLE_INIT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BOUNCE_HI: begin
                    if (seg_q == DELAY_W'(1)) begin
                        state_q <= BOUNCE_LO;
                        sw_q    <= ~target_q;
                        seg_q   <= seg_d;
                    end else begin
                        seg_q <= seg_q - DELAY_W'(1);
                    end
                end
                BOUNCE_LO: begin
                    if (seg_q == DELAY_W'(1)) begin
                        sw_q     <= target_q;
                        bounce_q <= bounce_q - BOUNCE_W'(1);
                        if (bounce_q == BOUNCE_W'(1)) begin
                            state_q  <= SETTLE;
                            seg_q    <= '0;
                            settle_q <= SETTLE_INIT;
                        end else begin
                            state_q <= BOUNCE_HI;
                            seg_q   <= seg_d;
                        end
                    end else begin
                        seg_q <= seg_q - DELAY_W'(1);
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_W'(1)) begin
                        state_q  <= DONE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q - SETTLE_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE) || (state_q == DONE);
    assign busy_o      = !cmd_ready_o;
    assign done_o      = (state_q == DONE);
    assign sw_o        = sw_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: predicts every sw_o level, busy/done timing and
// edge count from an independent LFSR model and the segment-length helper.
module tb_bounce_gen;
    import bounce_gen_pkg::*;

    localparam int          DELAY_W  = 4;
    localparam int          BOUNCE_W = 4;
    localparam int          STABLE   = 32;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                cmd_valid_i = 1'b0;
    logic                cmd_level_i = 1'b0;
    logic [BOUNCE_W-1:0] cmd_bounces_i = '0;
    logic                cmd_ready_o;
    logic                sw_o;
    logic                busy_o;
    logic                done_o;

    int n_chk = 0;
    int n_bad = 0;
    int edge_n = 0;
    int chg[64];
    int nchg;
    int ref_chg[64];
    int ref_nchg;

    bounce_gen #(
        .DELAY_W       (DELAY_W),
        .BOUNCE_W      (BOUNCE_W),
        .STABLE_CYCLES (STABLE),
        .SEED          (SEED)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_level_i   (cmd_level_i),
        .cmd_bounces_i (cmd_bounces_i),
        .cmd_ready_o   (cmd_ready_o),
        .sw_o          (sw_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Index of the clock edge since reset release (first edge after release = 1).
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // LFSR contents after n clock edges following reset release.
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] s;
        s = SEED;
        for (int k = 0; k < n; k++) s = (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
        return s;
    endfunction

    // Called at #1 after an edge; returns the index of the accept edge.
    task automatic send(input logic lvl, input int n, output int a);
        cmd_valid_i   = 1'b1;
        cmd_level_i   = lvl;
        cmd_bounces_i = BOUNCE_W'(n);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        a = edge_n;
    endtask

    task automatic run_check(input string tag, input logic lvl, input int n, input logic prior,
                             input int a, input int poke, input bit b2b,
                             input logic b2b_lvl, input int b2b_n);
        int   bnd[32];
        int   e, done_idx, bad_sw, bad_busy, bad_done, edges, first_done;
        logic prev, exp_sw;
        e = a;
        for (int s = 0; s < 2 * n; s++) begin
            e = e + int'(seg_len(lfsr_after(e - 1), DELAY_W));
            bnd[s] = e;
        end
        done_idx = e + STABLE;
        bad_sw = 0; bad_busy = 0; bad_done = 0; edges = 0; first_done = -1;
        prev = prior; nchg = 0;
        for (int i = a; i <= done_idx; i++) begin
            if (i > a) begin @(posedge clk_i); #1; end
            cmd_valid_i = 1'b0;
            if (poke > 0 && i == a + poke) begin
                cmd_valid_i = 1'b1; cmd_level_i = ~lvl; cmd_bounces_i = BOUNCE_W'(5);
            end
            exp_sw = lvl;
            for (int s = 2 * n - 1; s >= 0; s--) if (i < bnd[s]) exp_sw = lvl ^ s[0];
            if (sw_o !== exp_sw) bad_sw++;
            if (sw_o !== prev) begin
                edges++;
                if (nchg < 64) begin chg[nchg] = i - a; nchg++; end
            end
            prev = sw_o;
            if (i < done_idx && busy_o !== 1'b1) bad_busy++;
            if (done_o !== (i == done_idx)) bad_done++;
            if (done_o === 1'b1 && first_done < 0) first_done = i - a;
            if (i == done_idx) begin
                chk({tag, "_ready_in_done"}, cmd_ready_o, 1);
                if (b2b) begin
                    cmd_valid_i = 1'b1; cmd_level_i = b2b_lvl; cmd_bounces_i = BOUNCE_W'(b2b_n);
                end
            end
        end
        chk({tag, "_sw_trace_bad"}, bad_sw, 0);
        chk({tag, "_busy_bad"}, bad_busy, 0);
        chk({tag, "_done_bad"}, bad_done, 0);
        chk({tag, "_edges"}, edges, 2 * n + ((lvl != prior) ? 1 : 0));
        chk({tag, "_done_lat"}, first_done, done_idx - a);
        if (!b2b) begin
            @(posedge clk_i); #1;
            chk({tag, "_done_pulse"}, done_o, 0);
            chk({tag, "_idle_ready"}, cmd_ready_o, 1);
            chk({tag, "_idle_busy"}, busy_o, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int miss;
        bit found;
        #3;
        chk("rst_sw", sw_o, 0);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        send(1'b1, 3, a);
        run_check("t1_n3_rise", 1'b1, 3, 1'b0, a, 0, 1'b0, 1'b0, 0);
        ref_chg  = chg;
        ref_nchg = nchg;

        send(1'b0, 0, a);
        run_check("t2_n0_fall", 1'b0, 0, 1'b1, a, 0, 1'b0, 1'b0, 0);
        send(1'b1, 0, a);
        run_check("t3_n0_rise", 1'b1, 0, 1'b0, a, 0, 1'b0, 1'b0, 0);

        // Same-level command with an ignored request while busy, then back-to-back.
        send(1'b1, 2, a);
        run_check("t4_n2_same", 1'b1, 2, 1'b1, a, 3, 1'b1, 1'b0, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        a = edge_n;
        chk("b2b_done_low", done_o, 0);
        chk("b2b_busy", busy_o, 1);
        chk("b2b_sw_first", sw_o, 0);
        run_check("t5_b2b", 1'b0, 1, 1'b1, a, 0, 1'b0, 1'b0, 0);

        // Reset during BOUNCE_LO, then replay the power-up command.
        send(1'b1, 3, a);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk_i); #1;
            if (sw_o === 1'b0 && busy_o === 1'b1) found = 1'b1;
        end
        chk("mid_reached_lo", found, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_sw", sw_o, 0);
        chk("mid_rst_ready", cmd_ready_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        send(1'b1, 3, a);
        run_check("t6_rerun", 1'b1, 3, 1'b0, a, 0, 1'b0, 1'b0, 0);
        chk("rerun_nchg", nchg, ref_nchg);
        miss = 0;
        for (int k = 0; k < nchg && k < 64; k++) if (chg[k] != ref_chg[k]) miss++;
        chk("rerun_seg_offsets", miss, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
